// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths, MMIO address and read-pipeline stage type for cpu_mem_responder
package cpu_mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] MMIO_ADDR = 16'hFFFE;
  typedef logic [DATA_W-1:0] word_t;
  typedef struct packed {
    logic  valid;
    word_t data;
  } rd_stage_t;
endpackage

// File: rtl/cpu_mem_rd_pipe.sv
// cpu_mem_rd_pipe: RD_LATENCY-cycle read pipeline whose output register holds its last loaded value
module cpu_mem_rd_pipe
  import cpu_mem_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rd_stage_t req,
  output word_t     rddata
);
  rd_stage_t last;
  word_t rddata_q, rddata_d;
  if (RD_LATENCY == 1) begin : g_direct
    assign last = req;
  end else begin : g_shift
    rd_stage_t sr_q [RD_LATENCY-1];
    rd_stage_t sr_d [RD_LATENCY-1];
    always_comb begin
      sr_d[0] = req;
      for (int i = 1; i < RD_LATENCY - 1; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= '{default: '0};
      else sr_q <= sr_d;
    assign last = sr_q[RD_LATENCY-2];
  end
  always_comb rddata_d = last.valid ? last.data : rddata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rddata_q <= '0;
    else rddata_q <= rddata_d;
  assign rddata = rddata_q;
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: dual-port word RAM serving CPU fetch and load/store ports; CPUMEM_MMIO_EN adds an MMIO output register at 16'hFFFE
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 4096,
  parameter int    RD_LATENCY  = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_pc_rd,
  output word_t             o_pc_rddata,
  input  logic [ADDR_W-1:0] i_ldst_addr,
  input  logic              i_ldst_rd,
  input  logic              i_ldst_wr,
  input  word_t             i_ldst_wrdata,
  output word_t             o_ldst_rddata
`ifdef CPUMEM_MMIO_EN
  ,
  output word_t             o_mmio_out
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  word_t mem [DEPTH_WORDS];
  logic [1:0] sync_q;
  logic wr_ok_q;
  logic rst_n, pc_in, ld_in, ld_mmio, ram_we, unused_bits;
  word_t mmio_q;
  rd_stage_t pc_req, ld_req;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= {sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge reset)
    if (!reset) wr_ok_q <= 1'b0;
    else wr_ok_q <= sync_q[0];
  assign rst_n = sync_q[1];
  assign unused_bits = ^{i_pc_addr[0], i_ldst_addr[0]};
  assign pc_in = {1'b0, i_pc_addr[15:1]} < 16'(DEPTH_WORDS);
  assign ld_in = {1'b0, i_ldst_addr[15:1]} < 16'(DEPTH_WORDS);
`ifdef CPUMEM_MMIO_EN
  if (DEPTH_WORDS >= 32768) begin : g_bad_depth
    $error("CPUMEM_MMIO_EN needs DEPTH_WORDS < 32768 so the MMIO word is free");
  end
  word_t mmio_d;
  assign ld_mmio = i_ldst_addr[15:1] == MMIO_ADDR[15:1];
  always_comb mmio_d = i_ldst_wr && ld_mmio ? i_ldst_wrdata : mmio_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mmio_q <= '0;
    else mmio_q <= mmio_d;
  assign o_mmio_out = mmio_q;
`else
  assign ld_mmio = 1'b0;
  assign mmio_q = '0;
`endif
  assign ram_we = i_ldst_wr && wr_ok_q && ld_in && !ld_mmio;
  always_ff @(posedge clk)
    if (ram_we) mem[i_ldst_addr[AW:1]] <= i_ldst_wrdata;
  assign pc_req = '{valid: i_pc_rd, data: pc_in ? mem[i_pc_addr[AW:1]] : '0};
  assign ld_req = '{valid: i_ldst_rd, data: ld_mmio ? mmio_q : ld_in ? mem[i_ldst_addr[AW:1]] : '0};
  cpu_mem_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_pc_pipe (
    .clk(clk), .rst_n(rst_n), .req(pc_req), .rddata(o_pc_rddata)
  );
  cpu_mem_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_ld_pipe (
    .clk(clk), .rst_n(rst_n), .req(ld_req), .rddata(o_ldst_rddata)
  );
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed and randomized checks of cpu_mem_responder at read latencies 1, 2 and 3
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;
`ifdef CPUMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif
  localparam int DEPTH = 4096;
  localparam int HIST = 8192;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pc_addr = '0, ld_addr = '0;
  word_t wrdata = '0;
  logic pc_rd = 1'b0, ld_rd = 1'b0, ld_wr = 1'b0;
  word_t pc_o [3];
  word_t ld_o [3];
`ifdef CPUMEM_MMIO_EN
  word_t mmio_o [3];
`endif
  word_t mem_m [DEPTH];
  word_t mmio_m = '0;
  bit hv [2][HIST];
  word_t hd [2][HIST];
  int ec = 0, rst_floor = 0, checks = 0, errors = 0;
  bit active = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_mem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(g + 1)) u_dut (
      .clk(clk),
      .reset(reset),
      .i_pc_addr(pc_addr),
      .i_pc_rd(pc_rd),
      .o_pc_rddata(pc_o[g]),
      .i_ldst_addr(ld_addr),
      .i_ldst_rd(ld_rd),
      .i_ldst_wr(ld_wr),
      .i_ldst_wrdata(wrdata),
      .o_ldst_rddata(ld_o[g])
`ifdef CPUMEM_MMIO_EN
      ,
      .o_mmio_out(mmio_o[g])
`endif
    );
  end
  task automatic idle();
    pc_rd = 1'b0;
    ld_rd = 1'b0;
    ld_wr = 1'b0;
  endtask
  // reference: each accepted request records the word it should return; stores then update the model
  task automatic cycle();
    int pi, li;
    bit lm;
    pi = int'(pc_addr[15:1]);
    li = int'(ld_addr[15:1]);
    lm = MMIO && ld_addr[15:1] == 15'h7FFF;
    if (ec >= HIST - 1) begin
      $display("FAIL history: cycle budget %0d exhausted", HIST);
      $fatal(1);
    end
    if (active) begin
      hv[0][ec] = pc_rd;
      hd[0][ec] = pi < DEPTH ? mem_m[pi] : '0;
      hv[1][ec] = ld_rd;
      hd[1][ec] = lm ? mmio_m : li < DEPTH ? mem_m[li] : '0;
      if (ld_wr) begin
        if (lm) mmio_m = wrdata;
        else if (li < DEPTH) mem_m[li] = wrdata;
      end
    end
    @(posedge clk);
    #1;
    ec++;
  endtask
  // output after the latest edge is the newest request at least lat-1 edges old, else the reset value
  function automatic word_t exp_o(int p, int lat);
    for (int j = ec - lat; j >= rst_floor && j >= 0; j--)
      if (hv[p][j]) return hd[p][j];
    return '0;
  endfunction
  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    return r < 7 ? 16'($urandom_range(0, 127)) : r < 9 ? 16'($urandom_range(16'h2000, 16'hFFFF)) : 16'hFFFE;
  endfunction
  task automatic enter_reset();
    reset = 1'b0;
    active = 1'b0;
    rst_floor = ec;
    mmio_m = '0;
  endtask
  task automatic test_reset();
    idle();
    #1;
    enter_reset();
    repeat (3) cycle();
    for (int l = 0; l < 3; l++) begin
      checks += 2;
      if (pc_o[l] !== 16'h0000) begin errors++; $display("FAIL reset_pc L%0d: got %h want 0000", l + 1, pc_o[l]); end
      if (ld_o[l] !== 16'h0000) begin errors++; $display("FAIL reset_ld L%0d: got %h want 0000", l + 1, ld_o[l]); end
`ifdef CPUMEM_MMIO_EN
      checks++;
      if (mmio_o[l] !== 16'h0000) begin errors++; $display("FAIL reset_mmio L%0d: got %h want 0000", l + 1, mmio_o[l]); end
`endif
    end
    reset = 1'b1;
    cycle();
    cycle();
    active = 1'b1;
  endtask
  task automatic preload();
    for (int w = 0; w < 64; w++) begin
      idle();
      ld_wr = 1'b1;
      ld_addr = 16'(2 * w);
      wrdata = 16'($urandom);
      cycle();
    end
    idle();
  endtask
  task automatic test_fetch();
    idle();
    ld_wr = 1'b1; ld_addr = 16'h0010; wrdata = 16'h1234;
    cycle();
    idle();
    pc_rd = 1'b1; pc_addr = 16'h0010;
    cycle();
    idle();
    checks += 2;
    if (pc_o[0] !== 16'h1234) begin errors++; $display("FAIL fetch_l1: got %h want 1234", pc_o[0]); end
    if (pc_o[1] !== 16'h0000) begin errors++; $display("FAIL fetch_l2_early: got %h want 0000", pc_o[1]); end
    repeat (3) begin
      cycle();
      checks++;
      if (pc_o[0] !== 16'h1234) begin errors++; $display("FAIL fetch_hold: got %h want 1234", pc_o[0]); end
    end
    for (int l = 1; l < 3; l++) begin
      checks++;
      if (pc_o[l] !== 16'h1234) begin errors++; $display("FAIL fetch_lat L%0d: got %h want 1234", l + 1, pc_o[l]); end
    end
    pc_rd = 1'b1; pc_addr = 16'h0013;
    cycle();
    idle();
    checks++;
    if (pc_o[0] !== mem_m[9]) begin errors++; $display("FAIL fetch_bit0: got %h want %h", pc_o[0], mem_m[9]); end
    cycle();
    cycle();
  endtask
  task automatic test_back_to_back();
    word_t abc [3];
    word_t want;
    int d;
    abc = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
    for (int k = 0; k < 3; k++) begin
      idle();
      ld_wr = 1'b1; ld_addr = 16'(2 * k); wrdata = abc[k];
      cycle();
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      pc_rd = k < 3;
      pc_addr = 16'(2 * k);
      cycle();
      for (int l = 0; l < 3; l++) begin
        d = k - l;
        want = d < 0 ? exp_o(0, l + 1) : d > 2 ? abc[2] : abc[d];
        checks++;
        if (pc_o[l] !== want) begin errors++; $display("FAIL stream L%0d step %0d: got %h want %h", l + 1, k, pc_o[l], want); end
      end
    end
    idle();
  endtask
  task automatic test_collision();
    idle();
    ld_wr = 1'b1; ld_addr = 16'h0020; wrdata = 16'h0001;
    cycle();
    pc_rd = 1'b1; pc_addr = 16'h0020; ld_rd = 1'b1; wrdata = 16'hBEEF;
    cycle();
    checks += 2;
    if (pc_o[0] !== 16'h0001) begin errors++; $display("FAIL coll_pc_old: got %h want 0001", pc_o[0]); end
    if (ld_o[0] !== 16'h0001) begin errors++; $display("FAIL coll_ld_old: got %h want 0001", ld_o[0]); end
    ld_wr = 1'b0;
    cycle();
    idle();
    checks += 3;
    if (pc_o[0] !== 16'hBEEF) begin errors++; $display("FAIL coll_pc_new: got %h want beef", pc_o[0]); end
    if (ld_o[0] !== 16'hBEEF) begin errors++; $display("FAIL coll_ld_new: got %h want beef", ld_o[0]); end
    if (pc_o[1] !== 16'h0001) begin errors++; $display("FAIL coll_pc_l2: got %h want 0001", pc_o[1]); end
    cycle();
    checks += 2;
    if (pc_o[2] !== 16'h0001) begin errors++; $display("FAIL coll_pc_l3_old: got %h want 0001", pc_o[2]); end
    if (pc_o[1] !== 16'hBEEF) begin errors++; $display("FAIL coll_pc_l2_new: got %h want beef", pc_o[1]); end
    cycle();
    checks++;
    if (pc_o[2] !== 16'hBEEF) begin errors++; $display("FAIL coll_pc_l3_new: got %h want beef", pc_o[2]); end
  endtask
  task automatic test_out_of_range();
    idle();
    ld_rd = 1'b1; ld_addr = 16'h2000; pc_rd = 1'b1; pc_addr = 16'hFFFE;
    cycle();
    idle();
    cycle();
    cycle();
    for (int l = 0; l < 3; l++) begin
      checks += 2;
      if (ld_o[l] !== 16'h0000) begin errors++; $display("FAIL oor_ld L%0d: got %h want 0000", l + 1, ld_o[l]); end
      if (pc_o[l] !== 16'h0000) begin errors++; $display("FAIL oor_pc L%0d: got %h want 0000", l + 1, pc_o[l]); end
    end
    ld_wr = 1'b1; ld_addr = 16'h2000; wrdata = 16'hFFFF;
    cycle();
    idle();
    ld_rd = 1'b1; ld_addr = 16'h0000;
    cycle();
    idle();
    cycle();
    cycle();
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (ld_o[l] !== 16'hA0A0) begin errors++; $display("FAIL oor_store_dropped L%0d: got %h want a0a0", l + 1, ld_o[l]); end
    end
  endtask
  task automatic test_reset_mid();
    idle();
    ld_wr = 1'b1; ld_addr = 16'h0030; wrdata = 16'h5A5A;
    cycle();
    idle();
    ld_rd = 1'b1; ld_addr = 16'h0030;
    cycle();
    idle();
    enter_reset();
    #1;
    for (int l = 0; l < 3; l++) begin
      checks += 2;
      if (ld_o[l] !== 16'h0000) begin errors++; $display("FAIL rst_async_ld L%0d: got %h want 0000", l + 1, ld_o[l]); end
      if (pc_o[l] !== 16'h0000) begin errors++; $display("FAIL rst_async_pc L%0d: got %h want 0000", l + 1, pc_o[l]); end
    end
    ld_wr = 1'b1; ld_addr = 16'h0030; wrdata = 16'hDEAD;
    repeat (3) begin
      cycle();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (ld_o[l] !== 16'h0000) begin errors++; $display("FAIL rst_hold L%0d: got %h want 0000", l + 1, ld_o[l]); end
      end
    end
    idle();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 1) active = 1'b1;
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (ld_o[l] !== 16'h0000) begin errors++; $display("FAIL rst_late_update L%0d: got %h want 0000", l + 1, ld_o[l]); end
      end
    end
    ld_rd = 1'b1; ld_addr = 16'h0030;
    cycle();
    idle();
    cycle();
    cycle();
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (ld_o[l] !== 16'h5A5A) begin errors++; $display("FAIL rst_store_dropped L%0d: got %h want 5a5a", l + 1, ld_o[l]); end
    end
  endtask
`ifdef CPUMEM_MMIO_EN
  task automatic test_mmio();
    idle();
    ld_wr = 1'b1; ld_addr = 16'hFFFE; wrdata = 16'h00A5;
    cycle();
    idle();
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (mmio_o[l] !== 16'h00A5) begin errors++; $display("FAIL mmio_out L%0d: got %h want 00a5", l + 1, mmio_o[l]); end
    end
    ld_rd = 1'b1; ld_addr = 16'hFFFE; pc_rd = 1'b1; pc_addr = 16'hFFFE;
    cycle();
    idle();
    cycle();
    cycle();
    for (int l = 0; l < 3; l++) begin
      checks += 2;
      if (ld_o[l] !== 16'h00A5) begin errors++; $display("FAIL mmio_load L%0d: got %h want 00a5", l + 1, ld_o[l]); end
      if (pc_o[l] !== 16'h0000) begin errors++; $display("FAIL mmio_fetch L%0d: got %h want 0000", l + 1, pc_o[l]); end
    end
  endtask
`endif
  task automatic test_random();
    word_t wp, wl;
    for (int n = 0; n < 403; n++) begin
      idle();
      if (n < 400) begin
        pc_rd = 1'($urandom_range(0, 1));
        pc_addr = rand_addr();
        ld_rd = 1'($urandom_range(0, 1));
        ld_wr = $urandom_range(0, 2) == 0;
        ld_addr = rand_addr();
        wrdata = 16'($urandom);
      end
      cycle();
      for (int l = 0; l < 3; l++) begin
        wp = exp_o(0, l + 1);
        wl = exp_o(1, l + 1);
        checks += 2;
        if (pc_o[l] !== wp) begin errors++; $display("FAIL rand_pc L%0d cycle %0d: got %h want %h", l + 1, n, pc_o[l], wp); end
        if (ld_o[l] !== wl) begin errors++; $display("FAIL rand_ld L%0d cycle %0d: got %h want %h", l + 1, n, ld_o[l], wl); end
      end
    end
    idle();
  endtask
  initial begin
    test_reset();
    preload();
    test_fetch();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_reset_mid();
`ifdef CPUMEM_MMIO_EN
    test_mmio();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
